// File: rtl/mips_pkg.sv
// mips_pkg
// Shared encodings for the EX stage: MIPS opcode/funct values, the EX FSM
// state type, the internal ALU operation type and the decode helper that
// maps an opcode/funct pair onto an operation.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } ex_state_t;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_ADDI,
        ALU_MULT,
        ALU_MFHI,
        ALU_MFLO,
        ALU_UNK
    } alu_op_t;

    function automatic alu_op_t decode_op(input logic [5:0] opcode,
                                          input logic [5:0] funct);
        alu_op_t op;
        op = ALU_UNK;
        if (opcode == OP_ADDI) begin
            op = ALU_ADDI;
        end else if (opcode == OP_RTYPE) begin
            case (funct)
                FN_ADD:  op = ALU_ADD;
                FN_SUB:  op = ALU_SUB;
                FN_AND:  op = ALU_AND;
                FN_OR:   op = ALU_OR;
                FN_SLT:  op = ALU_SLT;
                FN_MULT: op = ALU_MULT;
                FN_MFHI: op = ALU_MFHI;
                FN_MFLO: op = ALU_MFLO;
                default: op = ALU_UNK;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/booth_mult_seq.sv
// booth_mult_seq
// Sequential signed radix-2 Booth multiplier, one step per clock, WIDTH steps.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset (aborts)
//   start           load M/Q and begin (ignored while busy)
//   M, Q            signed multiplicand / multiplier
//   busy            a multiply is in progress
//   done            combinational: this edge performs the final step
//   product         combinational {A,Q} after the current step; valid with done
module booth_mult_seq
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     M,
    input  logic [WIDTH-1:0]     Q,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    // A and M carry one guard bit so that A - M is exact for M = most-negative.
    logic [WIDTH:0]   r_a;
    logic [WIDTH:0]   r_m;
    logic [WIDTH-1:0] r_q;
    logic             r_q1;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_a_next;
    logic [WIDTH-1:0] w_q_next;
    logic             w_q1_next;

    always_comb begin
        w_sum = r_a;
        case ({r_q[0], r_q1})
            2'b01:   w_sum = r_a + r_m;
            2'b10:   w_sum = r_a - r_m;
            default: w_sum = r_a;
        endcase
        // Arithmetic shift right of {A,Q,Q_1}
        w_a_next  = {w_sum[WIDTH], w_sum[WIDTH:1]};
        w_q_next  = {w_sum[0], r_q[WIDTH-1:1]};
        w_q1_next = r_q[0];
    end

    assign busy    = r_busy;
    assign done    = r_busy && (r_cnt == CNT_W'(1));
    assign product = {w_a_next[WIDTH-1:0], w_q_next};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_m    <= '0;
            r_q    <= '0;
            r_q1   <= 1'b0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (start && !r_busy) begin
            r_a    <= '0;
            r_m    <= {M[WIDTH-1], M};
            r_q    <= Q;
            r_q1   <= 1'b0;
            r_cnt  <= CNT_W'(WIDTH);
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_a   <= w_a_next;
            r_q   <= w_q_next;
            r_q1  <= w_q1_next;
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/execute_booth_stage.sv
// execute_booth_stage
// EX stage: single-cycle ALU (ADD/SUB/AND/OR/SLT/ADDI, MFHI/MFLO) plus a
// sequential Booth MULT writing HI/LO. Decode is stalled while MULT runs.
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   in_valid                 Decode presents an instruction
//   Opcode                   instr[31:26]
//   Read_Data_1/2            rs / rt values
//   Sign_Extended_Immediate  immediate; [5:0] is funct for R-type
//   rt, rd                   destination register candidates
//   stall                    Decode must hold; inputs ignored this cycle
//   out_valid                one-cycle pulse per completed instruction
//   ALU_Result               registered result
//   Write_Reg                rd for R-type, rt for ADDI
//   RegWrite_out             destination must be written
module execute_booth_stage
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [5:0]       Opcode,
    input  logic [WIDTH-1:0] Read_Data_1,
    input  logic [WIDTH-1:0] Read_Data_2,
    input  logic [WIDTH-1:0] Sign_Extended_Immediate,
    input  logic [4:0]       rt,
    input  logic [4:0]       rd,
    output logic             stall,
    output logic             out_valid,
    output logic [WIDTH-1:0] ALU_Result,
    output logic [4:0]       Write_Reg,
    output logic             RegWrite_out
);

    ex_state_t        r_state;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic [4:0]       r_wreg;
    logic             r_regwrite;

    alu_op_t          w_op;
    logic [WIDTH-1:0] w_result;
    logic [4:0]       w_wreg;
    logic             w_regwrite;
    logic             w_accept;
    logic             w_mult_start;
    logic             w_mult_busy;
    logic             w_mult_done;
    logic [2*WIDTH-1:0] w_product;

    assign stall        = (r_state == ST_BUSY);
    assign w_accept     = in_valid && (r_state == ST_IDLE);
    assign w_mult_start = w_accept && (w_op == ALU_MULT) && !w_mult_busy;

    always_comb begin
        w_op       = decode_op(Opcode, Sign_Extended_Immediate[5:0]);
        w_result   = '0;
        w_wreg     = rd;
        w_regwrite = 1'b1;
        case (w_op)
            ALU_ADD:  w_result = Read_Data_1 + Read_Data_2;
            ALU_SUB:  w_result = Read_Data_1 - Read_Data_2;
            ALU_AND:  w_result = Read_Data_1 & Read_Data_2;
            ALU_OR:   w_result = Read_Data_1 | Read_Data_2;
            ALU_SLT:  w_result = {{(WIDTH-1){1'b0}},
                                  ($signed(Read_Data_1) < $signed(Read_Data_2))};
            ALU_ADDI: begin
                w_result = Read_Data_1 + Sign_Extended_Immediate;
                w_wreg   = rt;
            end
            ALU_MFHI: w_result = r_hi;
            ALU_MFLO: w_result = r_lo;
            default: begin
                w_result   = '0;
                w_regwrite = 1'b0;
            end
        endcase
    end

    booth_mult_seq #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mult (
        .clk     (clk),
        .rst     (rst),
        .start   (w_mult_start),
        .M       (Read_Data_1),
        .Q       (Read_Data_2),
        .busy    (w_mult_busy),
        .done    (w_mult_done),
        .product (w_product)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_hi        <= '0;
            r_lo        <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_wreg      <= '0;
            r_regwrite  <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_op == ALU_MULT) begin
                            r_state <= ST_BUSY;
                        end else begin
                            r_out_valid <= 1'b1;
                            r_result    <= w_result;
                            r_regwrite  <= w_regwrite;
                            // Unknown instructions leave the destination field untouched
                            if (w_op != ALU_UNK) begin
                                r_wreg <= w_wreg;
                            end
                        end
                    end
                end
                ST_BUSY: begin
                    if (w_mult_done) begin
                        r_state     <= ST_IDLE;
                        r_hi        <= w_product[2*WIDTH-1:WIDTH];
                        r_lo        <= w_product[WIDTH-1:0];
                        r_out_valid <= 1'b1;
                        r_regwrite  <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_valid    = r_out_valid;
    assign ALU_Result   = r_result;
    assign Write_Reg    = r_wreg;
    assign RegWrite_out = r_regwrite;

endmodule
